// File: rtl/dm_cache_if.sv
// Processor data port and BRAM port-B bundle for dm_cache_ctrl.
// The cache uses the slave modport; the master side is the processor and the BRAM.
interface dm_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              pro_req;
    logic              pro_we;
    logic [ADDR_W-1:0] pro_addr;
    logic [DATA_W-1:0] pro_wdata;
    logic [DATA_W-1:0] pro_rdata;
    logic              pro_ready;
    logic              hit;
    logic              flush;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  pro_req, pro_we, pro_addr, pro_wdata, flush, mem_rdata,
        output pro_rdata, pro_ready, hit, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output pro_req, pro_we, pro_addr, pro_wdata, flush, mem_rdata,
        input  pro_rdata, pro_ready, hit, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
// Define CACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 4,
    parameter int MEM_LAT = 1
) (
    input  logic        clk_100,
    input  logic        rst,
`ifdef CACHE_STATS_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    dm_cache_if.slave   bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {IDLE, MISS_WAIT, FILL, WRITE, FLUSH} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [2:0]         lat_cnt;
    logic [INDEX_W-1:0] flush_idx;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               line_hit;

    assign req_idx  = bus.pro_addr[INDEX_W-1:0];
    assign req_tag  = bus.pro_addr[ADDR_W-1:INDEX_W];
    // The miss address is held on mem_addr, so the fill needs no extra register.
    assign fill_idx = bus.mem_addr[INDEX_W-1:0];
    assign fill_tag = bus.mem_addr[ADDR_W-1:INDEX_W];
    assign line_hit = valid[req_idx] && (tag_q[req_idx] == req_tag);

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            lat_cnt       <= '0;
            flush_idx     <= '0;
            bus.pro_ready <= 1'b0;
            bus.hit       <= 1'b0;
            bus.pro_rdata <= '0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef CACHE_STATS_EN
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`endif
        end else begin
            bus.pro_ready <= 1'b0;
            bus.hit       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state     <= FLUSH;
                        bus.busy  <= 1'b1;
                        flush_idx <= '0;
                    end else if (bus.pro_req && !bus.pro_we) begin
                        if (line_hit) begin
                            bus.pro_ready <= 1'b1;
                            bus.hit       <= 1'b1;
                            bus.pro_rdata <= data_q[req_idx];
`ifdef CACHE_STATS_EN
                            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
`endif
                        end else begin
                            state        <= MISS_WAIT;
                            bus.busy     <= 1'b1;
                            bus.mem_en   <= 1'b1;
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= bus.pro_addr;
                            lat_cnt      <= '0;
                        end
                    end else if (bus.pro_req && bus.pro_we) begin
                        state         <= WRITE;
                        bus.busy      <= 1'b1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.pro_addr;
                        bus.mem_wdata <= bus.pro_wdata;
                        if (line_hit) data_q[req_idx] <= bus.pro_wdata;
                    end
                end
                MISS_WAIT: begin
                    if (lat_cnt == 3'(MEM_LAT - 1)) state <= FILL;
                    else                            lat_cnt <= lat_cnt + 3'd1;
                end
                FILL: begin
                    valid[fill_idx]  <= 1'b1;
                    tag_q[fill_idx]  <= fill_tag;
                    data_q[fill_idx] <= bus.mem_rdata;
                    bus.pro_ready    <= 1'b1;
                    bus.pro_rdata    <= bus.mem_rdata;
                    bus.mem_en       <= 1'b0;
                    bus.busy         <= 1'b0;
                    state            <= IDLE;
`ifdef CACHE_STATS_EN
                    if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
                end
                WRITE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.pro_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    if (flush_idx == '1) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios plus random traffic against an
// array-based cache model and a behavioural BRAM with MEM_LAT read latency.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int INDEX_W = 4;
    localparam int MEM_LAT = 1;
    localparam int LINES   = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    logic clk_100 = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_100 = ~clk_100;

    dm_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .MEM_LAT(MEM_LAT)) dut (
        .clk_100 (clk_100),
        .rst     (rst),
`ifdef CACHE_STATS_EN
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
`endif
        .bus     (bus)
    );

    // Behavioural BRAM: unwritten words return a fixed address hash.
    bit   [DATA_W-1:0] bram_w   [0:(1<<ADDR_W)-1];
    bit                bram_vld [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe  [MEM_LAT];

    function automatic logic [DATA_W-1:0] bram_val(input logic [ADDR_W-1:0] a);
        if (bram_vld[a]) return bram_w[a];
        if (a == 16'h0012) return 16'hBEEF;
        return ({a[7:0], a[15:8]} ^ 16'hA5C3) + a;
    endfunction

    always @(posedge clk_100) begin
        if (bus.mem_en && bus.mem_we) begin
            bram_w[bus.mem_addr]   <= bus.mem_wdata;
            bram_vld[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_we) rd_pipe[0] <= bram_val(bus.mem_addr);
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference cache contents and expected statistics.
    bit                ref_valid [LINES];
    logic [TAG_W-1:0]  ref_tag   [LINES];
    logic [DATA_W-1:0] ref_data  [LINES];
    int exp_hits, exp_miss;
    int errors = 0;
    int checks = 0;

    task automatic model_clear(input bit clr_stats);
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        if (clr_stats) begin exp_hits = 0; exp_miss = 0; end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.pro_req = 1'b0;
        bus.flush   = 1'b0;
        repeat (2) @(posedge clk_100);
        #1 rst = 1'b0;
        model_clear(1'b1);
    endtask

    // One processor transaction; with_flush raises flush together with pro_req.
    task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input bit with_flush);
        int idx, lat, en_cyc, we_cyc, exp_lat;
        logic [TAG_W-1:0]  tg;
        logic [DATA_W-1:0] exp_data;
        bit exp_hit, bad_mem;
        idx = int'(addr) % LINES;
        tg  = addr[ADDR_W-1:INDEX_W];
        if (with_flush) model_clear(1'b0);
        exp_hit  = !we && ref_valid[idx] && ref_tag[idx] == tg;
        exp_data = exp_hit ? ref_data[idx] : bram_val(addr);
        exp_lat  = (with_flush ? LINES + 1 : 0) + (we ? 2 : (exp_hit ? 1 : MEM_LAT + 2));
        lat = 0; en_cyc = 0; we_cyc = 0; bad_mem = 1'b0;
        bus.pro_we    = we;
        bus.pro_addr  = addr;
        bus.pro_wdata = wdata;
        bus.pro_req   = 1'b1;
        bus.flush     = with_flush;
        do begin
            @(posedge clk_100); #1;
            lat++;
            bus.flush = 1'b0;
            if (bus.mem_en) begin
                en_cyc++;
                if (bus.mem_we) we_cyc++;
                if (bus.mem_addr !== addr || (bus.mem_we && bus.mem_wdata !== wdata)) bad_mem = 1'b1;
            end
        end while (!bus.pro_ready && lat < 200);
        bus.pro_req = 1'b0;

        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL latency addr=%h we=%0d: got %0d want %0d", addr, we, lat, exp_lat);
        end
        checks++;
        if (bus.hit !== exp_hit) begin
            errors++; $display("FAIL hit addr=%h: got %b want %b", addr, bus.hit, exp_hit);
        end
        if (!we) begin
            checks++;
            if (bus.pro_rdata !== exp_data) begin
                errors++; $display("FAIL rdata addr=%h: got %h want %h", addr, bus.pro_rdata, exp_data);
            end
        end
        checks++;
        if (we ? (we_cyc != 1 || en_cyc != 1 || bad_mem)
               : (exp_hit ? (en_cyc != 0) : (en_cyc == 0 || we_cyc != 0 || bad_mem))) begin
            errors++;
            $display("FAIL mem_port addr=%h we=%0d: en_cyc=%0d we_cyc=%0d bad=%0d", addr, we, en_cyc, we_cyc, bad_mem);
        end
        @(posedge clk_100); #1;
        checks++;
        if (bus.pro_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_after addr=%h: ready=%b busy=%b want 0 0", addr, bus.pro_ready, bus.busy);
        end

        if (!we && exp_hit) exp_hits++;
        if (!we && !exp_hit) begin
            exp_miss++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_data[idx]  = exp_data;
        end
        if (we && ref_valid[idx] && ref_tag[idx] == tg) ref_data[idx] = wdata;
    endtask

    task automatic test_reset();
        bus.pro_req = 1'b0; bus.pro_we = 1'b0; bus.flush = 1'b0;
        bus.pro_addr = '0; bus.pro_wdata = '0;
        repeat (3) @(posedge clk_100);
        #1;
        checks++;
        if ({bus.pro_ready, bus.hit, bus.pro_rdata, bus.busy, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        rst = 1'b0;
        model_clear(1'b1);
    endtask

    task automatic test_read_hit_miss();
        do_op(1'b0, 16'h0012, '0, 1'b0);
        do_op(1'b0, 16'h0012, '0, 1'b0);
    endtask

    task automatic test_write();
        do_op(1'b1, 16'h0012, 16'h1234, 1'b0);
        do_op(1'b0, 16'h0012, '0, 1'b0);
        do_op(1'b1, 16'h0032, 16'h5678, 1'b0);
        do_op(1'b0, 16'h0032, '0, 1'b0);
    endtask

    task automatic test_conflict();
        do_op(1'b0, 16'h0003, '0, 1'b0);
        do_op(1'b0, 16'h0013, '0, 1'b0);
        do_op(1'b0, 16'h0003, '0, 1'b0);
        do_op(1'b0, 16'hFFFF, '0, 1'b0);
        do_op(1'b0, 16'hFFFF, '0, 1'b0);
        do_op(1'b0, 16'h000F, '0, 1'b0);
        do_op(1'b0, 16'hFFFF, '0, 1'b0);
    endtask

    task automatic test_flush();
        int busy_cyc;
        do_op(1'b0, 16'h0021, '0, 1'b0);
        do_op(1'b0, 16'h0021, '0, 1'b0);
        bus.flush = 1'b1;
        @(posedge clk_100); #1;
        bus.flush = 1'b0;
        busy_cyc = 0;
        while (bus.busy && busy_cyc < 100) begin
            busy_cyc++;
            @(posedge clk_100); #1;
        end
        checks++;
        if (busy_cyc != LINES) begin
            errors++; $display("FAIL flush_busy: got %0d cycles want %0d", busy_cyc, LINES);
        end
        model_clear(1'b0);
        do_op(1'b0, 16'h0021, '0, 1'b0);
        do_op(1'b0, 16'h0021, '0, 1'b0);
        do_op(1'b0, 16'h0021, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_op(1'b0, 16'h0040, '0, 1'b0);
        do_op(1'b0, 16'h0040, '0, 1'b0);
        bus.pro_we = 1'b0; bus.pro_addr = 16'h0055; bus.pro_req = 1'b1;
        @(posedge clk_100); #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0055) begin
            errors++; $display("FAIL miss_start: busy=%b en=%b addr=%h want 1 1 0055", bus.busy, bus.mem_en, bus.mem_addr);
        end
        rst = 1'b1; bus.pro_req = 1'b0;
        @(posedge clk_100); #1;
        rst = 1'b0;
        checks++;
        if ({bus.pro_ready, bus.hit, bus.pro_rdata, bus.busy, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got nonzero outputs, want all 0");
        end
        model_clear(1'b1);
        do_op(1'b0, 16'h0040, '0, 1'b0);
    endtask

    task automatic test_stats();
        apply_reset();
        do_op(1'b0, 16'h0101, '0, 1'b0);
        do_op(1'b0, 16'h0101, '0, 1'b0);
        do_op(1'b0, 16'h0101, '0, 1'b0);
        do_op(1'b0, 16'h0202, '0, 1'b0);
        do_op(1'b0, 16'h0202, '0, 1'b0);
        do_op(1'b0, 16'h0202, '0, 1'b0);
        do_op(1'b0, 16'h0303, '0, 1'b0);
        do_op(1'b0, 16'h0303, '0, 1'b0);
`ifdef CACHE_STATS_EN
        checks++;
        if (miss_cnt !== 16'd3 || hit_cnt !== 16'd5) begin
            errors++; $display("FAIL stats_3_5: got miss=%0d hit=%0d want 3 5", miss_cnt, hit_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [TAG_W-1:0]   t;
        logic [INDEX_W-1:0] i;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       t = '0;
                1:       t = TAG_W'(1);
                2:       t = '1;
                default: t = TAG_W'($urandom);
            endcase
            i = INDEX_W'($urandom_range(0, LINES - 1));
            do_op(1'($urandom_range(0, 3) == 0), {t, i}, DATA_W'($urandom),
                  $urandom_range(0, 24) == 0);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (miss_cnt !== 16'(exp_miss) || hit_cnt !== 16'(exp_hits)) begin
            errors++; $display("FAIL stats_random: got miss=%0d hit=%0d want %0d %0d", miss_cnt, hit_cnt, exp_miss, exp_hits);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_hit_miss();
        test_write();
        test_conflict();
        test_flush();
        test_reset_mid();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped, write-through, no-write-allocate cache controller between the processor data port and the dual-port block RAM (port B).
- Successor to the fixed 16-bit combinational cache. Adds generic width and depth, valid bits, a configurable BRAM read latency, a ready/request handshake that stalls the processor on a miss, and a flush command.

Parameters:
ADDR_W, 16, address width in words
DATA_W, 16, data word width
INDEX_W, 4, index bits; the cache holds 2^INDEX_W one-word lines
MEM_LAT, 1, BRAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk_100  in  1  single clock
rst  in  1  synchronous, active-high reset
pro_req  in  1  processor request; held high until pro_ready
pro_we  in  1  1 = write, 0 = read; sampled with pro_req
pro_addr  in  ADDR_W  word address
pro_wdata  in  DATA_W  write data
pro_rdata  out  DATA_W  read data; valid while pro_ready=1 on a read
pro_ready  out  1  one-cycle completion pulse
hit  out  1  1 with pro_ready when a read was served from the cache
flush  in  1  invalidate all lines; one-cycle pulse
busy  out  1  high in any state other than IDLE
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data

Behaviour:
- One clock (clk_100); reset is synchronous, active-high (rst).
- Storage per line: valid bit, tag of ADDR_W-INDEX_W bits, data of DATA_W bits.
  - index = pro_addr[INDEX_W-1:0]; tag = upper address bits.
- Reset values:
  - pro_ready=0, hit=0, pro_rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All valid bits = 0. State = IDLE.
- Reset mid-operation: abandons any miss, write or flush in progress. Returns to IDLE with every valid bit cleared.
- FSM states: IDLE, MISS_WAIT, FILL, WRITE, FLUSH.
- IDLE, request sampled at edge N; outputs appear at edge N+1. Priority order:
  - flush=1: go to FLUSH, regardless of pro_req.
  - Read hit (valid and tag match): stay in IDLE. pro_ready=1, hit=1, pro_rdata=line data at N+1. Hit latency is 1 cycle.
  - Read miss: go to MISS_WAIT. mem_en=1, mem_we=0, mem_addr=pro_addr at N+1.
  - Write: go to WRITE. mem_en=1, mem_we=1, mem_addr=pro_addr, mem_wdata=pro_wdata at N+1.
    - On a write hit the line data is updated at the same edge.
    - On a write miss the line is left untouched (no allocate).
- MISS_WAIT: counts MEM_LAT cycles with mem_en held and the address stable, then goes to FILL.
- FILL: captures mem_rdata into the line and sets valid and tag. pro_ready=1, hit=0, pro_rdata=mem_rdata. Returns to IDLE.
  - Read-miss latency: MEM_LAT+2 cycles from the request edge to pro_ready.
- WRITE: one cycle. mem_en and mem_we drop; pro_ready=1, hit=0. Returns to IDLE. Write latency is 2 cycles.
- FLUSH: clears one valid bit per cycle, index 0 up to 2^INDEX_W-1. Returns to IDLE after the last index.
  - busy=1 throughout; pro_req is ignored (not lost: the processor keeps it held).
- Flush and pro_req on the same edge: flush wins, and the request is served after the flush completes.
- pro_ready is a single-cycle pulse.
  - A pro_req still high in the cycle after pro_ready is treated as a new request. The processor must drop or change the request on receiving pro_ready.
- pro_rdata holds its last value when pro_ready=0.
- Address wrap: the highest address ((2^ADDR_W)-1) maps to index 2^INDEX_W-1 like any other address. There is no special case.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0.
  - hit_cnt increments on every read-hit pro_ready; miss_cnt increments on every FILL.
  - Both saturate at 16'hFFFF. Neither is affected by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read 16'h0012 (BRAM holds 16'hBEEF) with MEM_LAT=1:
  - mem_en at N+1, pro_ready at N+3, rdata=16'hBEEF, hit=0.
  - Repeating the same read gives pro_ready at N+1 with hit=1.
- Write 16'h0012 <- 16'h1234 after the line is cached:
  - mem_we pulses 1 cycle with addr 16'h0012 and data 16'h1234; pro_ready at N+2.
  - A following read returns 16'h1234 with hit=1 and no mem_en.
- Conflict: read 16'h0003, then read 16'h0013 (same index, different tag) -> second read misses.
  - Then read 16'h0003 -> misses again; mem_en asserted each time.
- Flush with INDEX_W=4: busy high for 16 cycles; the next read of a previously cached address gives hit=0.
  - flush and pro_req asserted together: request completes after busy falls.
- rst asserted during MISS_WAIT with MEM_LAT=3:
  - Next cycle all outputs are 0 and state is IDLE; the prior line read misses.
- With CACHE_STATS_EN defined: 3 misses and 5 hits -> miss_cnt=3, hit_cnt=5.
